sram_arbiter: RTL and testbench

- Sequences and shares the single external 8-bit SRAM between the machine core (primary requester) and an auxiliary loader port (SD/ROM loader, secondary requester).
- After reset, first performs a one-shot boot read of the video-configuration byte, then arbitrates all SRAM cycles.
- Sits at top level between the core/loader and the SRAM pins; drives the SRAM address, data and write-enable pins; all tristate control lives here.

---
 rtl/sram_arbiter_if.sv | 15 +
 rtl/sram_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for one SRAM client (core or loader).
// The master modport is the requester; the slave modport is the arbiter side.
interface sram_arbiter_if #(
  parameter int ADDR_W = 21
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/sram_arbiter.sv
// Shares the external 8-bit SRAM between the core and the loader port, after a
// one-shot boot read of the video-configuration byte.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_BOOT | reading CFG_ADDR into cfg_data, no grants
//   ST_IDLE | slot boundary, arbitrate core vs aux
//   ST_RD   | read slot: ACC_CYCLES access cycles + ack cycle
//   ST_WR   | write slot: setup / strobe / hold
module sram_arbiter #(
  parameter int                ADDR_W     = 21,
  parameter logic [ADDR_W-1:0] CFG_ADDR   = 21'h008FD5,
  parameter int                ACC_CYCLES = 2,
  parameter int                MAX_DEFER  = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  sram_arbiter_if.slave     core,
  sram_arbiter_if.slave     aux,
  output logic [7:0]        cfg_data,
  output logic              cfg_valid,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [7:0]        SRAM_DATA,
  output logic              SRAM_WE_n
);
  localparam int CNT_W = $clog2(ACC_CYCLES + 3);
  localparam int DEF_W = $clog2(MAX_DEFER + 1);

  typedef enum logic [1:0] {ST_BOOT, ST_IDLE, ST_RD, ST_WR} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DEF_W-1:0]  defer_cnt;
  logic              sel_aux;
  logic              data_oe;
  logic [7:0]        wdata_q;

  logic              aux_win;
  logic              core_win;
  logic              grant_we;
  logic [ADDR_W-1:0] grant_addr;
  logic [7:0]        grant_wdata;

  always_comb begin
    aux_win     = aux.req && (!core.req || defer_cnt == DEF_W'(MAX_DEFER));
    core_win    = core.req && !aux_win;
    grant_we    = aux_win ? aux.we    : core.we;
    grant_addr  = aux_win ? aux.addr  : core.addr;
    grant_wdata = aux_win ? aux.wdata : core.wdata;
  end

  assign SRAM_DATA = data_oe ? wdata_q : 8'hzz;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= ST_BOOT;
      cnt        <= CNT_W'(ACC_CYCLES);
      defer_cnt  <= '0;
      sel_aux    <= 1'b0;
      data_oe    <= 1'b0;
      wdata_q    <= '0;
      SRAM_ADDR  <= CFG_ADDR;
      SRAM_WE_n  <= 1'b1;
      core.ack   <= 1'b0;
      aux.ack    <= 1'b0;
      core.rdata <= '0;
      aux.rdata  <= '0;
      cfg_data   <= '0;
      cfg_valid  <= 1'b0;
    end else begin
      core.ack <= 1'b0;
      aux.ack  <= 1'b0;
      if (!aux.req) defer_cnt <= '0;

      case (state)
        ST_BOOT: begin
          if (cnt == '0) begin
            cfg_valid <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            if (cnt == CNT_W'(1)) cfg_data <= SRAM_DATA;
            cnt <= cnt - 1'b1;
          end
        end

        ST_IDLE: begin
          if (aux_win || core_win) begin
            sel_aux   <= aux_win;
            SRAM_ADDR <= grant_addr;
            wdata_q   <= grant_wdata;
            if (grant_we) begin
              state   <= ST_WR;
              data_oe <= 1'b1;
              cnt     <= CNT_W'(2);
            end else begin
              state <= ST_RD;
              cnt   <= CNT_W'(ACC_CYCLES);
            end
            // Count core wins only while the loader is actually waiting.
            if (aux_win) defer_cnt <= '0;
            else if (aux.req && defer_cnt != DEF_W'(MAX_DEFER))
              defer_cnt <= defer_cnt + 1'b1;
          end
        end

        ST_RD: begin
          if (cnt == '0) begin
            if (sel_aux) aux.ack  <= 1'b1;
            else         core.ack <= 1'b1;
            state <= ST_IDLE;
          end else begin
            if (cnt == CNT_W'(1)) begin
              if (sel_aux) aux.rdata  <= SRAM_DATA;
              else         core.rdata <= SRAM_DATA;
            end
            cnt <= cnt - 1'b1;
          end
        end

        ST_WR: begin
          // cnt 2 -> strobe next, 1 -> hold next, 0 -> release bus
          if (cnt == CNT_W'(2)) begin
            SRAM_WE_n <= 1'b0;
          end else if (cnt == CNT_W'(1)) begin
            SRAM_WE_n <= 1'b1;
            if (sel_aux) aux.ack  <= 1'b1;
            else         core.ack <= 1'b1;
          end else begin
            data_oe <= 1'b0;
            state   <= ST_IDLE;
          end
          if (cnt != '0) cnt <= cnt - 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: an SRAM device model on the pins plus a slot-level
// reference model (grant times, ack times, memory contents) checked every cycle.
module tb_sram_arbiter;
  localparam int          ADDR_W = 21;
  localparam logic [20:0] CFG    = 21'h008FD5;
  localparam int          ACC    = 2;
  localparam int          MAXD   = 4;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  sram_arbiter_if #(.ADDR_W(ADDR_W)) core_if ();
  sram_arbiter_if #(.ADDR_W(ADDR_W)) aux_if ();

  logic [7:0]        cfg_data;
  logic              cfg_valid;
  logic [ADDR_W-1:0] SRAM_ADDR;
  wire  [7:0]        SRAM_DATA;
  logic              SRAM_WE_n;

  sram_arbiter #(.ADDR_W(ADDR_W), .CFG_ADDR(CFG), .ACC_CYCLES(ACC), .MAX_DEFER(MAXD)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .core     (core_if),
    .aux      (aux_if),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DATA(SRAM_DATA),
    .SRAM_WE_n(SRAM_WE_n)
  );

  // SRAM device: drives the pins whenever the arbiter is not driving them
  logic [7:0] sram_mem [0:(1<<ADDR_W)-1];
  logic [7:0] sram_q;
  always_comb sram_q = sram_mem[SRAM_ADDR];
  assign SRAM_DATA = dut.data_oe ? 8'hzz : sram_q;

  typedef struct {
    logic        we;
    logic [20:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  txn_t        core_q[$];
  txn_t        aux_q[$];
  logic [7:0]  ref_mem [int];
  logic [20:0] pool [0:7];

  int n_total, n_bad;
  int cyc, idle_cyc, slot_g, streak;
  bit slot_act, slot_wr, slot_aux;
  logic [20:0] slot_addr;
  logic [7:0]  slot_wdata, slot_val, exp_core_rd, exp_aux_rd;
  bit core_pend, aux_pend, core_gnt, aux_gnt;
  int we_low_cnt, wait_core_acks, defer_exp, first_core_ack_cyc;
  bit cont_chk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = pool[$urandom_range(0, 7)];
    t.wdata = 8'($urandom);
    return t;
  endfunction

  task automatic model_reset();
    cyc = 0; idle_cyc = ACC + 1; slot_act = 0; slot_g = -100; slot_wr = 0; slot_aux = 0;
    streak = 0; exp_core_rd = 8'h00; exp_aux_rd = 8'h00;
    core_pend = 0; aux_pend = 0; core_gnt = 0; aux_gnt = 0;
    first_core_ack_cyc = -1; cont_chk = 0;
    core_q.delete(); aux_q.delete();
    core_if.req = 0; core_if.we = 0; core_if.addr = '0; core_if.wdata = '0;
    aux_if.req  = 0; aux_if.we  = 0; aux_if.addr  = '0; aux_if.wdata  = '0;
  endtask

  task automatic do_cycle();
    int   ack_c;
    bit   core_done, aux_done, in_slot, aw, cw;
    logic exp_we_n, exp_oe;
    txn_t t;
    ack_c     = slot_g + (slot_wr ? 2 : ACC + 1);
    core_done = slot_act && !slot_aux && cyc == ack_c;
    aux_done  = slot_act &&  slot_aux && cyc == ack_c;
    in_slot   = slot_act && cyc >= slot_g && cyc <= ack_c;
    exp_we_n  = !(slot_act && slot_wr && cyc == slot_g + 1);
    exp_oe    = slot_act && slot_wr && cyc >= slot_g && cyc <= slot_g + 2;
    if (core_done && !slot_wr) exp_core_rd = slot_val;
    if (aux_done  && !slot_wr) exp_aux_rd  = slot_val;

    chk("core_ack", 32'(core_if.ack), 32'(core_done));
    chk("aux_ack", 32'(aux_if.ack), 32'(aux_done));
    chk("we_n", 32'(SRAM_WE_n), 32'(exp_we_n));
    chk("data_drive", 32'(dut.data_oe), 32'(exp_oe));
    if (in_slot) chk("sram_addr", 32'(SRAM_ADDR), 32'(slot_addr));
    if (exp_oe) chk("sram_wdata", 32'(SRAM_DATA), 32'(slot_wdata));
    if (cyc < ACC + 1) chk("boot_addr", 32'(SRAM_ADDR), 32'(CFG));
    chk("cfg_valid", 32'(cfg_valid), 32'(cyc >= ACC + 1));
    if (cyc != ACC) chk("cfg_data", 32'(cfg_data), (cyc > ACC) ? 32'hA5 : 32'h0);
    if (!(slot_act && !slot_wr && !slot_aux && cyc == slot_g + ACC))
      chk("core_rdata", 32'(core_if.rdata), 32'(exp_core_rd));
    if (!(slot_act && !slot_wr && slot_aux && cyc == slot_g + ACC))
      chk("aux_rdata", 32'(aux_if.rdata), 32'(exp_aux_rd));

    if (!SRAM_WE_n) begin
      sram_mem[SRAM_ADDR] = SRAM_DATA;
      we_low_cnt++;
    end
    if (cont_chk && aux_pend && core_if.ack) wait_core_acks++;
    if (cont_chk && aux_done) chk("defer_slots", 32'(wait_core_acks), 32'(defer_exp));
    if (core_if.ack && first_core_ack_cyc < 0) first_core_ack_cyc = cyc;

    if (core_done) begin core_pend = 0; core_gnt = 0; end
    if (!core_pend && core_q.size() > 0) begin
      t = core_q.pop_front();
      core_if.req = 1; core_if.we = t.we; core_if.addr = t.addr; core_if.wdata = t.wdata;
      core_pend = 1;
    end else if (!core_pend) begin
      core_if.req = 0;
    end else if (core_gnt) begin
      t = rand_txn();
      core_if.we = t.we; core_if.addr = t.addr; core_if.wdata = t.wdata;
    end

    if (aux_done) begin aux_pend = 0; aux_gnt = 0; end
    if (!aux_pend && aux_q.size() > 0) begin
      t = aux_q.pop_front();
      aux_if.req = 1; aux_if.we = t.we; aux_if.addr = t.addr; aux_if.wdata = t.wdata;
      aux_pend = 1;
      wait_core_acks = 0;
      defer_exp = MAXD + ((slot_act && !slot_aux && cyc < ack_c) ? 1 : 0);
    end else if (!aux_pend) begin
      aux_if.req = 0;
    end else if (aux_gnt) begin
      t = rand_txn();
      aux_if.we = t.we; aux_if.addr = t.addr; aux_if.wdata = t.wdata;
    end

    // Slot-level arbitration for the edge that ends this cycle
    if (cyc >= idle_cyc) begin
      aw = aux_if.req && (!core_if.req || streak == MAXD);
      cw = core_if.req && !aw;
      if (aw || cw) begin
        slot_act   = 1;
        slot_g     = cyc + 1;
        slot_aux   = aw;
        slot_wr    = aw ? aux_if.we    : core_if.we;
        slot_addr  = aw ? aux_if.addr  : core_if.addr;
        slot_wdata = aw ? aux_if.wdata : core_if.wdata;
        if (slot_wr) ref_mem[int'(slot_addr)] = slot_wdata;
        slot_val   = ref_mem[int'(slot_addr)];
        idle_cyc   = slot_g + (slot_wr ? 3 : ACC + 1);
        core_gnt   = cw;
        aux_gnt    = aw;
      end
      if (aw) streak = 0;
      else if (cw && aux_if.req) streak++;
    end
    if (!aux_if.req) streak = 0;
  endtask

  task automatic step();
    @(negedge clk_sys);
    cyc++;
    do_cycle();
  endtask

  task automatic release_reset();
    @(negedge clk_sys);
    reset = 0;
    #1;
    do_cycle();
  endtask

  initial begin
    txn_t t;
    bit   found;
    n_total = 0; n_bad = 0; we_low_cnt = 0; wait_core_acks = 0; defer_exp = 0;
    pool[0] = 21'h000000; pool[1] = 21'h1FFFFF; pool[2] = 21'h000100; pool[3] = 21'h0AAAAA;
    pool[4] = 21'h155555; pool[5] = 21'h000001; pool[6] = 21'h1FFFFE; pool[7] = 21'h008FD4;
    for (int i = 0; i < 8; i++) begin
      sram_mem[pool[i]] = 8'($urandom);
      ref_mem[int'(pool[i])] = sram_mem[pool[i]];
    end
    sram_mem[CFG] = 8'hA5;

    // Boot with no requests
    model_reset();
    reset = 1;
    repeat (3) @(posedge clk_sys);
    release_reset();
    repeat (6) step();

    // Core write then read-back
    we_low_cnt = 0;
    t.we = 1; t.addr = 21'h000100; t.wdata = 8'h3C; core_q.push_back(t);
    t.we = 0; t.wdata = 8'h00; core_q.push_back(t);
    repeat (14) step();
    chk("we_low_cycles", 32'(we_low_cnt), 32'd1);
    chk("core_readback", 32'(core_if.rdata), 32'h3C);

    // Continuous core reads with a pending aux read
    for (int i = 0; i < 8; i++) begin
      t.we = 0; t.addr = pool[$urandom_range(0, 7)]; t.wdata = 8'h00; core_q.push_back(t);
    end
    repeat (2) step();
    cont_chk = 1;
    t.we = 0; t.addr = 21'h1FFFFF; t.wdata = 8'h00; aux_q.push_back(t);
    repeat (40) step();
    cont_chk = 0;

    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (!core_pend && !aux_pend && core_q.size() == 0 && aux_q.size() == 0) found = 1;
      else step();
    end
    chk("drain_timeout", 32'(found), 32'd1);

    // Aux only: write then read
    t.we = 1; t.addr = 21'h000000; t.wdata = 8'h77; aux_q.push_back(t);
    t.we = 0; t.wdata = 8'h00; aux_q.push_back(t);
    repeat (12) step();
    chk("aux_readback", 32'(aux_if.rdata), 32'h77);

    // Reset during the write strobe, core request held across reset release
    t.we = 1; t.addr = 21'h0AAAAA; t.wdata = 8'h5A; core_q.push_back(t);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (slot_act && slot_wr && !slot_aux && cyc == slot_g + 1) found = 1;
    end
    chk("strobe_reached", 32'(found), 32'd1);
    #1 reset = 1;
    #1;
    chk("rst_we_n", 32'(SRAM_WE_n), 32'd1);
    chk("rst_data_drive", 32'(dut.data_oe), 32'd0);
    chk("rst_core_ack", 32'(core_if.ack), 32'd0);
    chk("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    model_reset();
    repeat (2) @(posedge clk_sys);
    t.we = 0; t.addr = 21'h0AAAAA; t.wdata = 8'h00; core_q.push_back(t);
    release_reset();
    repeat (12) step();
    chk("boot_first_ack", 32'(first_core_ack_cyc), 32'(2 * ACC + 3));
    chk("rd_after_rst", 32'(core_if.rdata), 32'h5A);

    // Randomized traffic on both ports
    for (int i = 0; i < 1500; i++) begin
      if (core_q.size() == 0 && $urandom_range(0, 99) < 35) core_q.push_back(rand_txn());
      if (aux_q.size() == 0 && $urandom_range(0, 99) < 20) aux_q.push_back(rand_txn());
      step();
    end
    repeat (30) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
